ov7670_frame_emulator: RTL and testbench

//  Synthesizable OV7670 camera-side transmitter. Drives VSYNC/HREF/PCLK/D

---
 rtl/ov7670_frame_emulator.sv | 217 +++++++++++++++++++++
 tb/tb_ov7670_frame_emulator.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ov7670_frame_emulator.sv
// ov7670_frame_emulator
//   Camera-side OV7670 transmitter model. Generates VSYNC/HREF/PCLK/D with
//   sensor-like frame timing so the OV7670 receiver can be exercised on-board
//   and in simulation without a physical camera.
//
//   state  | meaning
//   IDLE   | waiting for iniciar, VSYNC high
//   VBP    | vertical back porch, VSYNC low, HREF low
//   ACTIVE | line bytes on D, HREF high
//   HBLANK | HREF low between lines
//   VFP    | vertical front porch after the last line
//   FIM    | one tick with VSYNC high, pronto pulse, then restart or idle
//
// Ports
//   clock     in   system clock
//   reset     in   asynchronous active-low reset
//   iniciar   in   start one frame (level, sampled in IDLE at a tick boundary)
//   continuo  in   chain the next frame after FIM (sampled only in FIM)
//   VSYNC     out  1 idle/between frames, 0 for the whole frame
//   HREF      out  1 while line bytes are valid
//   PCLK      out  pixel clock, receiver samples D on its rising edge
//   D         out  pixel byte (0 whenever HREF is low)
//   ocupado   out  1 while not IDLE
//   pronto    out  one-clock pulse on entry to FIM
//   db_estado out  state code (IDLE=0 .. FIM=5)
//
// Build option
//   OV7670_EMU_LFSR_EN: active bytes come from an 8-bit Fibonacci LFSR
//   (x^8+x^6+x^5+x^4+1) seeded 0xA5 at each VBP entry instead of a counter.

module ov7670_frame_emulator #(
  parameter int LINES           = 480,
  parameter int COLUMNS         = 640,
  parameter int BYTES_PER_PIXEL = 2,
  parameter int PCLK_DIV        = 2,
  parameter int V_PORCH         = 10,
  parameter int H_BLANK         = 144
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       iniciar,
  input  logic       continuo,
  output logic       VSYNC,
  output logic       HREF,
  output logic       PCLK,
  output logic [7:0] D,
  output logic       ocupado,
  output logic       pronto,
  output logic [3:0] db_estado
);

  localparam int BYTES_PER_LINE = COLUMNS * BYTES_PER_PIXEL;
  localparam int TMR_A   = (V_PORCH > H_BLANK) ? V_PORCH : H_BLANK;
  localparam int TMR_MAX = (TMR_A > BYTES_PER_LINE) ? TMR_A : BYTES_PER_LINE;
  // Timers are loaded with duration-1, so they never hold TMR_MAX itself.
  localparam int TW = (TMR_MAX > 1) ? $clog2(TMR_MAX) : 1;
  localparam int LW = (LINES > 1) ? $clog2(LINES) : 1;
  localparam int DW = $clog2(2 * PCLK_DIV);

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_VBP    = 4'd1,
    S_ACTIVE = 4'd2,
    S_HBLANK = 4'd3,
    S_VFP    = 4'd4,
    S_FIM    = 4'd5
  } state_t;

`ifdef OV7670_EMU_LFSR_EN
  localparam logic [7:0] DATA_SEED = 8'hA5;

  function automatic logic [7:0] data_next(input logic [7:0] v);
    return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
  endfunction
`else
  localparam logic [7:0] DATA_SEED = 8'h00;

  function automatic logic [7:0] data_next(input logic [7:0] v);
    return v + 8'd1;
  endfunction
`endif

  state_t          state_q, state_d;
  logic [DW-1:0]   div_q, div_d;
  logic            pclk_q, pclk_d;
  logic [TW-1:0]   tmr_q, tmr_d;
  logic [LW-1:0]   line_q, line_d;
  logic [7:0]      data_q, data_d;
  logic            vsync_q, vsync_d;
  logic            href_q, href_d;
  logic [7:0]      d_q, d_d;
  logic            pronto_q, pronto_d;
  logic            tick;
  logic            tmr_done;
  logic            start_frame;

  // A tick ends on the clock edge that drops PCLK; all frame outputs move
  // on that same edge so D is settled a full half-period around each rise.
  assign tick     = (div_q == DW'(2 * PCLK_DIV - 1));
  assign tmr_done = (tmr_q == '0);

  always_comb begin
    state_d     = state_q;
    tmr_d       = tmr_q;
    line_d      = line_q;
    data_d      = data_q;
    vsync_d     = vsync_q;
    href_d      = href_q;
    d_d         = d_q;
    pronto_d    = 1'b0;
    start_frame = 1'b0;

    div_d  = tick ? '0 : div_q + 1'b1;
    pclk_d = (div_d >= DW'(PCLK_DIV));

    if (tick) begin
      if (!tmr_done) tmr_d = tmr_q - 1'b1;
      case (state_q)
        S_IDLE: begin
          if (iniciar) start_frame = 1'b1;
        end
        S_VBP: begin
          if (tmr_done) begin
            state_d = S_ACTIVE;
            tmr_d   = TW'(BYTES_PER_LINE - 1);
            href_d  = 1'b1;
            d_d     = data_q;
            data_d  = data_next(data_q);
          end
        end
        S_ACTIVE: begin
          if (tmr_done) begin
            href_d = 1'b0;
            d_d    = 8'd0;
            if (line_q == LW'(LINES - 1)) begin
              state_d = S_VFP;
              tmr_d   = TW'(V_PORCH - 1);
            end else begin
              state_d = S_HBLANK;
              tmr_d   = TW'(H_BLANK - 1);
            end
          end else begin
            d_d    = data_q;
            data_d = data_next(data_q);
          end
        end
        S_HBLANK: begin
          if (tmr_done) begin
            state_d = S_ACTIVE;
            line_d  = line_q + 1'b1;
            tmr_d   = TW'(BYTES_PER_LINE - 1);
            href_d  = 1'b1;
            d_d     = data_q;
            data_d  = data_next(data_q);
          end
        end
        S_VFP: begin
          if (tmr_done) begin
            state_d  = S_FIM;
            vsync_d  = 1'b1;
            pronto_d = 1'b1;
          end
        end
        S_FIM: begin
          if (continuo) start_frame = 1'b1;
          else          state_d     = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase

      if (start_frame) begin
        state_d = S_VBP;
        tmr_d   = TW'(V_PORCH - 1);
        line_d  = '0;
        data_d  = DATA_SEED;
        vsync_d = 1'b0;
        href_d  = 1'b0;
        d_d     = 8'd0;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      div_q    <= '0;
      pclk_q   <= 1'b0;
      tmr_q    <= '0;
      line_q   <= '0;
      data_q   <= 8'd0;
      vsync_q  <= 1'b1;
      href_q   <= 1'b0;
      d_q      <= 8'd0;
      pronto_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      div_q    <= div_d;
      pclk_q   <= pclk_d;
      tmr_q    <= tmr_d;
      line_q   <= line_d;
      data_q   <= data_d;
      vsync_q  <= vsync_d;
      href_q   <= href_d;
      d_q      <= d_d;
      pronto_q <= pronto_d;
    end
  end

  assign VSYNC     = vsync_q;
  assign HREF      = href_q;
  assign PCLK      = pclk_q;
  assign D         = d_q;
  assign pronto    = pronto_q;
  assign ocupado   = (state_q != S_IDLE);
  assign db_estado = state_q;

endmodule

// File: tb/tb_ov7670_frame_emulator.sv
`timescale 1ns/1ps
module tb_ov7670_frame_emulator;

  localparam int BPP  = 2;
  localparam int A_L  = 2, A_C = 2,   A_DIV = 1, A_VP = 2, A_HB = 3;
  localparam int B_L  = 2, B_C = 128, B_DIV = 3, B_VP = 2, B_HB = 3;

  typedef logic [14:0] smp_t;  // {vsync, href, ocupado, db[3:0], d[7:0]}

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic reset, iniciar, continuo, sel;
  logic ini_a, ini_b, cont_a, cont_b;
  logic vs_a, hr_a, pc_a, oc_a, pr_a, vs_b, hr_b, pc_b, oc_b, pr_b;
  logic [7:0] d_a, d_b;
  logic [3:0] db_a, db_b;
  logic m_vs, m_hr, m_pc, m_oc, m_pr;
  logic [7:0] m_d;
  logic [3:0] m_db;

  assign ini_a  = iniciar  & ~sel;
  assign ini_b  = iniciar  &  sel;
  assign cont_a = continuo & ~sel;
  assign cont_b = continuo &  sel;
  assign m_vs = sel ? vs_b : vs_a;
  assign m_hr = sel ? hr_b : hr_a;
  assign m_pc = sel ? pc_b : pc_a;
  assign m_oc = sel ? oc_b : oc_a;
  assign m_pr = sel ? pr_b : pr_a;
  assign m_d  = sel ? d_b  : d_a;
  assign m_db = sel ? db_b : db_a;

  ov7670_frame_emulator #(.LINES(A_L), .COLUMNS(A_C), .BYTES_PER_PIXEL(BPP),
    .PCLK_DIV(A_DIV), .V_PORCH(A_VP), .H_BLANK(A_HB)) dut_a (
    .clock(clock), .reset(reset), .iniciar(ini_a), .continuo(cont_a),
    .VSYNC(vs_a), .HREF(hr_a), .PCLK(pc_a), .D(d_a),
    .ocupado(oc_a), .pronto(pr_a), .db_estado(db_a));

  ov7670_frame_emulator #(.LINES(B_L), .COLUMNS(B_C), .BYTES_PER_PIXEL(BPP),
    .PCLK_DIV(B_DIV), .V_PORCH(B_VP), .H_BLANK(B_HB)) dut_b (
    .clock(clock), .reset(reset), .iniciar(ini_b), .continuo(cont_b),
    .VSYNC(vs_b), .HREF(hr_b), .PCLK(pc_b), .D(d_b),
    .ocupado(oc_b), .pronto(pr_b), .db_estado(db_b));

  int n_cmp = 0, n_bad = 0;
  smp_t exp_q[$], obs_q[$];
  int pronto_clks, glitch, per_bad;

  function automatic smp_t pack(input logic vs, input logic hr, input logic oc,
                                input logic [3:0] db, input logic [7:0] d);
    return {vs, hr, oc, db, d};
  endfunction

  // Reference frame: one entry per PCLK rise, derived from the frame layout.
  task automatic build_frame(input int lines, input int cols, input int vp, input int hb);
`ifdef OV7670_EMU_LFSR_EN
    logic [7:0] v;
    v = 8'hA5;
`else
    int k;
    k = 0;
`endif
    repeat (vp) exp_q.push_back(pack(1'b0, 1'b0, 1'b1, 4'd1, 8'd0));
    for (int l = 0; l < lines; l++) begin
      for (int b = 0; b < cols * BPP; b++) begin
`ifdef OV7670_EMU_LFSR_EN
        exp_q.push_back(pack(1'b0, 1'b1, 1'b1, 4'd2, v));
        v = {v[6:0], ^(v & 8'hB8)};
`else
        exp_q.push_back(pack(1'b0, 1'b1, 1'b1, 4'd2, 8'(k % 256)));
        k++;
`endif
      end
      if (l < lines - 1) repeat (hb) exp_q.push_back(pack(1'b0, 1'b0, 1'b1, 4'd3, 8'd0));
    end
    repeat (vp) exp_q.push_back(pack(1'b0, 1'b0, 1'b1, 4'd4, 8'd0));
    exp_q.push_back(pack(1'b1, 1'b0, 1'b1, 4'd5, 8'd0));
  endtask

  task automatic add_idle(input int n);
    repeat (n) exp_q.push_back(pack(1'b1, 1'b0, 1'b0, 4'd0, 8'd0));
  endtask

  // Records one sample per PCLK rise; must be entered at a negedge.
  task automatic collect(input int n, input int div);
    int budget, since;
    logic pp;
    smp_t prev, s;
    obs_q.delete();
    pronto_clks = 0; glitch = 0; per_bad = 0;
    budget = n * 2 * div + 4 * div + 10;
    since = 0;
    pp = m_pc;
    prev = pack(m_vs, m_hr, m_oc, m_db, m_d);
    while (obs_q.size() < n && budget > 0) begin
      @(negedge clock);
      budget--; since++;
      s = pack(m_vs, m_hr, m_oc, m_db, m_d);
      if (m_pr) pronto_clks++;
      if (s !== prev && !(pp == 1'b1 && m_pc == 1'b0)) glitch++;
      if (pp == 1'b0 && m_pc == 1'b1) begin
        obs_q.push_back(s);
        if (obs_q.size() > 1 && since != 2 * div) per_bad++;
        since = 0;
      end
      pp = m_pc;
      prev = s;
    end
  endtask

  task automatic wait_ocupado(input int div, output bit ok);
    int budget;
    ok = 1'b0;
    budget = 4 * div + 4;
    while (budget > 0 && !ok) begin
      @(negedge clock);
      budget--;
      if (m_oc === 1'b1) ok = 1'b1;
    end
  endtask

  task automatic test_reset();
    reset = 1'b0; iniciar = 1'b0; continuo = 1'b0; sel = 1'b0;
    repeat (3) @(negedge clock);
    n_cmp++; if (m_vs !== 1'b1) begin n_bad++; $display("FAIL reset_vsync: got %b expected 1", m_vs); end
    n_cmp++; if (m_hr !== 1'b0) begin n_bad++; $display("FAIL reset_href: got %b expected 0", m_hr); end
    n_cmp++; if (m_pc !== 1'b0) begin n_bad++; $display("FAIL reset_pclk: got %b expected 0", m_pc); end
    n_cmp++; if (m_d !== 8'd0) begin n_bad++; $display("FAIL reset_d: got %h expected 00", m_d); end
    n_cmp++; if ({m_oc, m_pr} !== 2'b00) begin n_bad++; $display("FAIL reset_flags: got %b expected 00", {m_oc, m_pr}); end
    n_cmp++; if (m_db !== 4'd0) begin n_bad++; $display("FAIL reset_state: got %0d expected 0", m_db); end
    reset = 1'b1;
    @(negedge clock);
    exp_q.delete();
    add_idle(4);
    collect(4, A_DIV);
    n_cmp++; if (obs_q.size() != exp_q.size()) begin n_bad++; $display("FAIL idle_len: got %0d expected %0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      n_cmp++; if (obs_q[i] !== exp_q[i]) begin n_bad++; $display("FAIL idle_tick[%0d]: got %h expected %h", i, obs_q[i], exp_q[i]); end
    end
    n_cmp++; if (per_bad != 0) begin n_bad++; $display("FAIL idle_pclk_period: got %0d bad periods expected 0", per_bad); end
  endtask

  task automatic test_single_frame();
    bit ok;
    sel = 1'b0; continuo = 1'b0;
    repeat ($urandom_range(0, 5)) @(negedge clock);
    iniciar = 1'b1;
    wait_ocupado(A_DIV, ok);
    iniciar = 1'b0;
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL single_start: got no start expected ocupado within 1 tick"); end
    exp_q.delete();
    build_frame(A_L, A_C, A_VP, A_HB);
    n_cmp++; if (exp_q.size() != 16) begin n_bad++; $display("FAIL single_model_len: got %0d expected 16", exp_q.size()); end
    add_idle(2);
    collect(exp_q.size(), A_DIV);
    n_cmp++; if (obs_q.size() != exp_q.size()) begin n_bad++; $display("FAIL single_len: got %0d expected %0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      n_cmp++; if (obs_q[i] !== exp_q[i]) begin n_bad++; $display("FAIL single_tick[%0d]: got %h expected %h", i, obs_q[i], exp_q[i]); end
    end
    n_cmp++; if (pronto_clks != 1) begin n_bad++; $display("FAIL single_pronto: got %0d clocks expected 1", pronto_clks); end
    n_cmp++; if (glitch != 0) begin n_bad++; $display("FAIL single_glitch: got %0d off-boundary changes expected 0", glitch); end
  endtask

  task automatic test_held_start();
    bit ok;
    sel = 1'b0; continuo = 1'b0;
    repeat ($urandom_range(0, 5)) @(negedge clock);
    iniciar = 1'b1;
    wait_ocupado(A_DIV, ok);
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL held_start: got no start expected ocupado within 1 tick"); end
    exp_q.delete();
    build_frame(A_L, A_C, A_VP, A_HB);
    collect(exp_q.size(), A_DIV);
    iniciar = 1'b0;
    n_cmp++; if (obs_q.size() != exp_q.size()) begin n_bad++; $display("FAIL held_len: got %0d expected %0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      n_cmp++; if (obs_q[i] !== exp_q[i]) begin n_bad++; $display("FAIL held_tick[%0d]: got %h expected %h", i, obs_q[i], exp_q[i]); end
    end
    n_cmp++; if (pronto_clks != 1) begin n_bad++; $display("FAIL held_pronto: got %0d clocks expected 1", pronto_clks); end
    exp_q.delete();
    add_idle(3);
    collect(3, A_DIV);
    for (int i = 0; i < exp_q.size(); i++) begin
      n_cmp++; if (i >= obs_q.size() || obs_q[i] !== exp_q[i]) begin n_bad++; $display("FAIL held_idle[%0d]: got %h expected %h", i, (i < obs_q.size()) ? obs_q[i] : 15'h7fff, exp_q[i]); end
    end
  endtask

  task automatic test_back_to_back();
    bit ok;
    int nf;
    nf = $urandom_range(2, 3);
    sel = 1'b0; continuo = 1'b1;
    repeat ($urandom_range(0, 5)) @(negedge clock);
    iniciar = 1'b1;
    wait_ocupado(A_DIV, ok);
    iniciar = 1'b0;
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL b2b_start: got no start expected ocupado within 1 tick"); end
    exp_q.delete();
    repeat (nf) build_frame(A_L, A_C, A_VP, A_HB);
    collect(exp_q.size(), A_DIV);
    continuo = 1'b0;
    n_cmp++; if (obs_q.size() != exp_q.size()) begin n_bad++; $display("FAIL b2b_len: got %0d expected %0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      n_cmp++; if (obs_q[i] !== exp_q[i]) begin n_bad++; $display("FAIL b2b_tick[%0d]: got %h expected %h", i, obs_q[i], exp_q[i]); end
    end
    n_cmp++; if (pronto_clks != nf) begin n_bad++; $display("FAIL b2b_pronto: got %0d expected %0d", pronto_clks, nf); end
    exp_q.delete();
    add_idle(2);
    collect(2, A_DIV);
    for (int i = 0; i < exp_q.size(); i++) begin
      n_cmp++; if (i >= obs_q.size() || obs_q[i] !== exp_q[i]) begin n_bad++; $display("FAIL b2b_idle[%0d]: got %h expected %h", i, (i < obs_q.size()) ? obs_q[i] : 15'h7fff, exp_q[i]); end
    end
  endtask

  task automatic test_async_reset();
    bit ok;
    int budget;
    sel = 1'b0; continuo = 1'b0;
    iniciar = 1'b1;
    wait_ocupado(A_DIV, ok);
    iniciar = 1'b0;
    ok = 1'b0; budget = 40;
    while (budget > 0 && !ok) begin
      @(negedge clock); budget--;
      if (m_db === 4'd2) ok = 1'b1;
    end
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL arst_reach_active: got state %0d expected 2", m_db); end
    repeat ($urandom_range(0, 3)) @(negedge clock);
    #2 reset = 1'b0;
    #1;
    n_cmp++; if ({m_vs, m_hr, m_pc, m_oc, m_pr} !== 5'b10000) begin n_bad++; $display("FAIL arst_ctrl: got %b expected 10000", {m_vs, m_hr, m_pc, m_oc, m_pr}); end
    n_cmp++; if ({m_db, m_d} !== 12'h000) begin n_bad++; $display("FAIL arst_data: got %h expected 000", {m_db, m_d}); end
    @(negedge clock);
    reset = 1'b1;
    repeat ($urandom_range(1, 4)) @(negedge clock);
    iniciar = 1'b1;
    wait_ocupado(A_DIV, ok);
    iniciar = 1'b0;
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL arst_restart: got no start expected ocupado within 1 tick"); end
    exp_q.delete();
    build_frame(A_L, A_C, A_VP, A_HB);
    add_idle(1);
    collect(exp_q.size(), A_DIV);
    n_cmp++; if (obs_q.size() != exp_q.size()) begin n_bad++; $display("FAIL arst_len: got %0d expected %0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      n_cmp++; if (obs_q[i] !== exp_q[i]) begin n_bad++; $display("FAIL arst_tick[%0d]: got %h expected %h", i, obs_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_slow_wrap();
    bit ok;
    int nb, fl;
    sel = 1'b1; continuo = 1'b1;
    repeat ($urandom_range(1, 7)) @(negedge clock);
    iniciar = 1'b1;
    wait_ocupado(B_DIV, ok);
    iniciar = 1'b0;
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL wrap_start: got no start expected ocupado within 1 tick"); end
    exp_q.delete();
    build_frame(B_L, B_C, B_VP, B_HB);
    fl = exp_q.size();
    build_frame(B_L, B_C, B_VP, B_HB);
    collect(exp_q.size(), B_DIV);
    continuo = 1'b0;
    n_cmp++; if (obs_q.size() != exp_q.size()) begin n_bad++; $display("FAIL wrap_len: got %0d expected %0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      n_cmp++; if (obs_q[i] !== exp_q[i]) begin n_bad++; $display("FAIL wrap_tick[%0d]: got %h expected %h", i, obs_q[i], exp_q[i]); end
    end
    n_cmp++; if (glitch != 0) begin n_bad++; $display("FAIL wrap_glitch: got %0d off-boundary changes expected 0", glitch); end
    n_cmp++; if (per_bad != 0) begin n_bad++; $display("FAIL wrap_pclk_period: got %0d bad periods expected 0", per_bad); end
    n_cmp++; if (pronto_clks != 2) begin n_bad++; $display("FAIL wrap_pronto: got %0d expected 2", pronto_clks); end
    for (int f = 0; f < 2; f++) begin
      nb = 0;
      for (int i = f * fl; i < (f + 1) * fl && i < obs_q.size(); i++) begin
        if (obs_q[i][13]) begin
`ifdef OV7670_EMU_LFSR_EN
          if (nb == 0) begin
            n_cmp++; if (obs_q[i][7:0] !== 8'hA5) begin n_bad++; $display("FAIL lfsr_first_byte: got %h expected a5", obs_q[i][7:0]); end
          end
`else
          if (nb == 256) begin
            n_cmp++; if (obs_q[i][7:0] !== 8'h00) begin n_bad++; $display("FAIL wrap_byte256: got %h expected 00", obs_q[i][7:0]); end
          end
`endif
          nb++;
        end
      end
      n_cmp++; if (nb != B_L * B_C * BPP) begin n_bad++; $display("FAIL wrap_byte_count: got %0d expected %0d", nb, B_L * B_C * BPP); end
    end
    exp_q.delete();
    add_idle(2);
    collect(2, B_DIV);
    for (int i = 0; i < exp_q.size(); i++) begin
      n_cmp++; if (i >= obs_q.size() || obs_q[i] !== exp_q[i]) begin n_bad++; $display("FAIL wrap_idle[%0d]: got %h expected %h", i, (i < obs_q.size()) ? obs_q[i] : 15'h7fff, exp_q[i]); end
    end
    sel = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_held_start();
    test_back_to_back();
    test_async_reset();
    test_slow_wrap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
